uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte producers. It sits in front of the `tx` instance inside `uart` and drives that instance's `tx_data`/`tx_rdy` request and watches its `tx_ack`. For each requester it returns a one-cycle completion pulse and an error pulse. A watchdog releases the transmitter if the acknowledge never comes.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_sched_rr_arbiter.sv | 29 ++
 rtl/uart_tx_sched.sv | 115 +++++++++++
 tb/tb_uart_tx_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int DATA_W              = 8;
   localparam int TIMEOUT_CYC_DEFAULT = 200000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } sched_st_t;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping.
// Zero latency; no state, so no backpressure of its own.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last,
   output logic [$clog2(N_REQ)-1:0] gnt_idx,
   output logic                     gnt_any
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] start;
   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;

   always_comb begin
      start   = (int'(last) == N_REQ - 1) ? '0 : last + 1'b1;
      // Rotate so the highest-priority slot lands at bit 0, then take the lowest set bit.
      rot     = N_REQ'({req, req} >> start);
      off     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      gnt_any = |req;
      gnt_idx = IDX_W'((int'(start) + int'(off)) % N_REQ);
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter: grant 1 cycle after req, ack/err 1 cycle
// after tx_ack or watchdog expiry, then a 1-cycle gap; requesters wait on req until ack/err.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [DATA_W*N_REQ-1:0]    req_data,
   output logic [N_REQ-1:0]           ack,
   output logic [N_REQ-1:0]           err,
   output logic                       tx_req,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_ack,
   output logic                       busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   sched_st_t         state_q, state_d;
   logic              tx_req_q, tx_req_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [N_REQ-1:0]  err_q, err_d;
   logic              busy_q, busy_d;

   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_any;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (req),
      .last    (last_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      state_d    = state_q;
      tx_req_d   = tx_req_q;
      tx_data_d  = tx_data_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      ack_d      = '0;
      err_d      = '0;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               grant_id_d = gnt_idx;
               last_d     = gnt_idx;
               tx_data_d  = req_data[DATA_W*gnt_idx +: DATA_W];
               tx_req_d   = 1'b1;
               cnt_d      = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            cnt_d = cnt_q + 1'b1;
            // Acceptance takes precedence over a watchdog expiry in the same cycle.
            if (tx_ack) begin
               tx_req_d          = 1'b0;
               ack_d[grant_id_q] = 1'b1;
               state_d           = GAP;
            end else if (cnt_q == CNT_LAST) begin
               tx_req_d          = 1'b0;
               err_d[grant_id_q] = 1'b1;
               state_d           = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         tx_req_q   <= 1'b0;
         tx_data_q  <= '0;
         grant_id_q <= '0;
         last_q     <= IDX_W'(N_REQ - 1);
         cnt_q      <= '0;
         ack_q      <= '0;
         err_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_req_q   <= tx_req_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_req   = tx_req_q;
   assign tx_data  = tx_data_q;
   assign grant_id = grant_id_q;
   assign ack      = ack_q;
   assign err      = err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-level reference model compared every cycle,
// directed scenarios with literal timing expectations, then randomized traffic.
module tb_uart_tx_sched;
   localparam int N  = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  ack, err;
   logic          tx_req;
   logic [7:0]    tx_data;
   logic          tx_ack;
   logic          busy;
   logic [1:0]    grant_id;

   uart_tx_sched #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .err      (err),
      .tx_req   (tx_req),
      .tx_data  (tx_data),
      .tx_ack   (tx_ack),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Reference model: one transfer record plus the cycle the link becomes free again.
   int         now     = 0;
   int         m_owner = -1;
   int         m_start = 0;
   int         m_free  = 0;
   int         m_last  = N - 1;
   logic       e_txreq = 1'b0;
   logic [7:0] e_data  = '0;
   logic [1:0] e_gid   = '0;
   logic       e_busy  = 1'b0;
   logic [N-1:0] e_ack = '0;
   logic [N-1:0] e_err = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         now = 0; m_owner = -1; m_start = 0; m_free = 0; m_last = N - 1;
         e_txreq = 1'b0; e_data = '0; e_gid = '0; e_busy = 1'b0; e_ack = '0; e_err = '0;
      end else begin
         e_ack = '0;
         e_err = '0;
         if (m_owner >= 0) begin
            if (tx_ack || (now - m_start == TO - 1)) begin
               if (tx_ack) e_ack[m_owner] = 1'b1;
               else        e_err[m_owner] = 1'b1;
               e_txreq = 1'b0;
               m_owner = -1;
               m_free  = now + 2;
            end
         end else if (now >= m_free && req != '0) begin
            int w;
            w = 0;
            for (int k = 1; k <= N; k++) begin
               w = (m_last + k) % N;
               if (req[w]) break;
            end
            m_owner = w;
            m_last  = w;
            m_start = now + 1;
            e_txreq = 1'b1;
            e_data  = req_data[8*w +: 8];
            e_gid   = 2'(w);
         end
         e_busy = (m_owner >= 0) || (now + 1 < m_free);
         now++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if ({tx_req, tx_data, grant_id, busy, ack, err} !==
             {e_txreq, e_data, e_gid, e_busy, e_ack, e_err}) begin
            n_fail++;
            $display("FAIL cycle_cmp @%0t got txreq=%b data=%h gid=%0d busy=%b ack=%b err=%b, expected txreq=%b data=%h gid=%0d busy=%b ack=%b err=%b",
                     $time, tx_req, tx_data, grant_id, busy, ack, err,
                     e_txreq, e_data, e_gid, e_busy, e_ack, e_err);
         end
      end
   end

   // Stimulus-side state: transmitter responder and requester behaviour knobs.
   int tcyc       = 0;
   int hi_cnt     = 0;
   int ack_dly    = 0;
   int last_txack = 0;
   bit rand_dly   = 1'b0;
   bit noise      = 1'b0;
   bit auto_drop  = 1'b1;
   bit rand_req   = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      tcyc++;
      if (tx_req) begin
         if (hi_cnt == 0 && rand_dly) ack_dly = $urandom_range(0, 20);
         tx_ack = (hi_cnt == ack_dly);
         if (tx_ack) last_txack = tcyc;
         hi_cnt++;
      end else begin
         hi_cnt = 0;
         tx_ack = noise && ($urandom_range(0, 3) == 0);
      end
      if (auto_drop) req = req & ~(ack | err);
      if (rand_req) begin
         for (int k = 0; k < N; k++) begin
            if (!req[k] && $urandom_range(0, 3) == 0) begin
               req[k] = 1'b1;
               req_data[8*k +: 8] = 8'($urandom);
            end
         end
      end
   endtask

   // want_done=0: wait for tx_req high; want_done=1: wait for an ack/err pulse.
   task automatic wait_ev(input bit want_done, output int t);
      bit hit;
      hit = 1'b0;
      t   = -1;
      for (int i = 0; i < 100 && !hit; i++) begin
         step();
         hit = want_done ? ((ack | err) != '0) : tx_req;
      end
      if (hit) t = tcyc;
      else begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_%s: no event within 100 cycles, required one", want_done ? "done" : "txreq");
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      int r, t;
      rst = 1'b1; req = '0; req_data = '0; tx_ack = 1'b0;
      #3 rst = 1'b0;
      chk_en = 1'b1;
      step();
      step();
      chk("rst_txreq", tx_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_ackerr", ack | err, 0);
      rst = 1'b1;
      step();

      // Single requester, tx_ack 10 cycles after tx_req rises.
      ack_dly = 10;
      req_data[7:0] = 8'hA5;
      req = 4'b0001;
      t = tcyc;
      wait_ev(0, r);
      chk("single_grant_lat", r - t, 1);
      chk("single_data", tx_data, 8'hA5);
      chk("single_gid", grant_id, 0);
      wait_ev(1, t);
      chk("single_ack_time", t - r, 11);
      chk("single_ack_vec", ack, 4'b0001);
      chk("single_txreq_low", tx_req, 0);
      step();
      chk("single_busy_low", busy, 0);

      // Round-robin fairness with all four held high.
      do_reset();
      auto_drop = 1'b0;
      ack_dly = 5;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_ev(0, r);
         chk("rr_gid", grant_id, g % 4);
         chk("rr_data", tx_data, 16 + (g % 4));
         if (g > 0) chk("rr_spacing", r - last_txack, 3);
         wait_ev(1, t);
      end
      req = '0;
      step();
      step();

      // Wrap and skip: after granting 2, request 0 and 1 with 0 held.
      do_reset();
      auto_drop = 1'b1;
      ack_dly = 0;
      req = 4'b0100;
      wait_ev(0, r);
      chk("wrap_first", grant_id, 2);
      wait_ev(1, t);
      auto_drop = 1'b0;
      req = 4'b0011;
      wait_ev(0, r);
      chk("wrap_gid0", grant_id, 0);
      wait_ev(1, t);
      wait_ev(0, r);
      chk("wrap_gid1", grant_id, 1);
      wait_ev(1, t);
      auto_drop = 1'b1;
      req = '0;
      step();
      step();

      // Watchdog expiry with no tx_ack.
      ack_dly = -1;
      req = 4'b0100;
      wait_ev(0, r);
      wait_ev(1, t);
      chk("to_time", t - r, TO);
      chk("to_err", err, 4'b0100);
      chk("to_ack", ack, 0);
      chk("to_txreq", tx_req, 0);
      step();

      // tx_ack on the final watchdog cycle: ack wins.
      ack_dly = TO - 1;
      req = 4'b0010;
      wait_ev(0, r);
      wait_ev(1, t);
      chk("tie_time", t - r, TO);
      chk("tie_ack", ack, 4'b0010);
      chk("tie_err", err, 0);
      step();

      // Reset in the middle of a transfer, then re-arbitration from index 0.
      ack_dly = -1;
      req_data[31:24] = 8'h5C;
      req = 4'b1000;
      wait_ev(0, r);
      chk("mid_gid", grant_id, 3);
      chk("mid_data", tx_data, 8'h5C);
      step();
      step();
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_txreq", tx_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", tx_data, 0);
      chk("mid_rst_gid", grant_id, 0);
      step();
      chk("mid_rst_ackerr", ack | err, 0);
      ack_dly = 1;
      req_data[15:8] = 8'hC3;
      req = 4'b1010;
      rst = 1'b1;
      wait_ev(0, r);
      chk("rearb_gid", grant_id, 1);
      chk("rearb_data", tx_data, 8'hC3);
      req = '0;
      wait_ev(1, t);
      chk("drop_still_acks", ack, 4'b0010);
      step();
      step();

      // Randomized traffic, compared cycle by cycle against the model.
      noise    = 1'b1;
      rand_dly = 1'b1;
      rand_req = 1'b1;
      repeat (3000) step();
      rand_req = 1'b0;
      rand_dly = 1'b0;
      ack_dly  = 2;
      repeat (100) step();
      noise = 1'b0;
      step();
      chk("drain_req", req, 0);
      chk("drain_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
